// File: rtl/seg7_capture.sv
// Passive 7-segment bus receiver: recovers the glyph on each multiplexed digit
// position and presents whole frames through a valid/ready handshake.
module seg7_capture #(
    parameter int N_DIGITS       = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_DIGITS-1:0]   an_n,
    input  logic [6:0]            seg_n,
    output logic [4*N_DIGITS-1:0] frame_value,
    output logic [N_DIGITS-1:0]   frame_err,
    output logic [N_DIGITS-1:0]   frame_blank,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun,
    output logic                  timeout
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int KW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic {WAIT, LATCHED} state_t;

    logic                rst_m, rst_int_n;
    logic [N_DIGITS-1:0] an_m, an_s, an_p;
    logic [6:0]          seg_m, seg_s, seg_p;
    logic                same, slot_ok, capture, complete, complete_q, idle_hit;
    logic [KW-1:0]       k;
    logic [6:0]          p;
    logic [3:0]          nib;
    logic                derr, dblank;
    logic [N_DIGITS-1:0] seen_q, seen_cap, err_q, blank_q;
    logic [N_DIGITS-1:0][3:0] val_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       idle_q;
    state_t              state_q, state_d;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_m     <= 1'b0;
            rst_int_n <= 1'b0;
        end else begin
            rst_m     <= 1'b1;
            rst_int_n <= rst_m;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            an_m  <= '1; an_s  <= '1; an_p  <= '1;
            seg_m <= '1; seg_s <= '1; seg_p <= '1;
        end else begin
            an_m  <= an_n;  an_s  <= an_m;  an_p  <= an_s;
            seg_m <= seg_n; seg_s <= seg_m; seg_p <= seg_s;
        end
    end

    assign same    = (an_s == an_p) && (seg_s == seg_p);
    assign slot_ok = $onehot(~an_s);

    always_comb begin
        k = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (!an_s[i]) k = KW'(i);
    end

    always_comb begin
        p      = ~seg_s;
        nib    = 4'h0;
        derr   = 1'b0;
        dblank = 1'b0;
        case (p)
            7'h3F: nib = 4'h0;  7'h06: nib = 4'h1;  7'h5B: nib = 4'h2;  7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;  7'h6D: nib = 4'h5;  7'h7D: nib = 4'h6;  7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;  7'h6F: nib = 4'h9;  7'h77: nib = 4'hA;  7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;  7'h5E: nib = 4'hD;  7'h79: nib = 4'hE;  7'h71: nib = 4'hF;
            7'h00: dblank = 1'b1;
            default: derr = 1'b1;
        endcase
    end

    // Counter tops out at STABLE_CYCLES-1, where the capture fires and clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        capture = 1'b0;
        case (state_q)
            WAIT: if (same && slot_ok) begin
                if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = LATCHED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCHED: if (!same || !slot_ok) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign seen_cap = seen_q | (N_DIGITS'(1) << k);
    assign complete = capture && (&seen_cap);
    assign idle_hit = !capture && (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            val_q      <= '0;
            err_q      <= '0;
            blank_q    <= '0;
            seen_q     <= '0;
            idle_q     <= '0;
            timeout    <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= complete;
            timeout    <= idle_hit && (|seen_q);
            if (capture) begin
                val_q[k]   <= nib;
                err_q[k]   <= derr;
                blank_q[k] <= dblank;
                seen_q     <= complete ? '0 : seen_cap;
                idle_q     <= '0;
            end else begin
                if (idle_q != TW'(TIMEOUT_CYCLES)) idle_q <= idle_q + 1'b1;
                if (idle_hit) seen_q <= '0;
            end
        end
    end

    // Store is stable for STABLE_CYCLES after a capture, so loading a cycle late is safe.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_value <= '0;
            frame_err   <= '0;
            frame_blank <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete_q) begin
                if (!frame_valid || frame_ready) begin
                    frame_value <= val_q;
                    frame_err   <= err_q;
                    frame_blank <= blank_q;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end
endmodule
